// File: rtl/qos_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// qos_pkg
// Shared constants and types for the QoS egress scheduler:
//   - geometry (queue count, weight range, table size, mode count)
//   - derived field widths (weight, queue id, mode, table pointer)
//   - arbitration mode encodings and FSM state encoding
// -----------------------------------------------------------------------------
package qos_pkg;

   localparam int QUEUE_QUANTITY    = 4;
   localparam int MAX_WEIGHT        = 64;
   localparam int TABLE_SIZE        = 8;
   localparam int TIPOS_ROUND_ROBIN = 3;

   localparam int W_WEIGHT = $clog2(MAX_WEIGHT);
   localparam int W_QID    = $clog2(QUEUE_QUANTITY);
   localparam int W_MODE   = $clog2(TIPOS_ROUND_ROBIN);
   localparam int W_TP     = $clog2(TABLE_SIZE);

   // Encoding 3 is not listed and decodes as plain round robin.
   localparam logic [W_MODE-1:0] MODE_RR    = W_MODE'(0);
   localparam logic [W_MODE-1:0] MODE_WRR   = W_MODE'(1);
   localparam logic [W_MODE-1:0] MODE_TABLE = W_MODE'(2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      SERVE = 2'd2
   } state_t;

endpackage

// File: rtl/qos_scheduler_if.sv
// -----------------------------------------------------------------------------
// qos_scheduler_if
// FIFO-side bundle of the egress scheduler.
//   fifo_empty  : per-FIFO empty flags            (FIFO side -> scheduler)
//   dest_full   : downstream almost-full          (FIFO side -> scheduler)
//   pop         : one-hot pop strobe              (scheduler -> FIFO side)
//   grant_id    : queue currently served          (scheduler -> FIFO side)
//   grant_valid : high while serving a burst      (scheduler -> FIFO side)
//   busy        : high while not idle             (scheduler -> FIFO side)
// Modports: master = scheduler, slave = FIFO/environment side.
// -----------------------------------------------------------------------------
interface qos_scheduler_if;
   import qos_pkg::*;

   logic [QUEUE_QUANTITY-1:0] fifo_empty;
   logic                      dest_full;
   logic [QUEUE_QUANTITY-1:0] pop;
   logic [W_QID-1:0]          grant_id;
   logic                      grant_valid;
   logic                      busy;

   modport master (
      input  fifo_empty, dest_full,
      output pop, grant_id, grant_valid, busy
   );

   modport slave (
      output fifo_empty, dest_full,
      input  pop, grant_id, grant_valid, busy
   );

endinterface

// File: rtl/qos_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// qos_rr_pick
// Rotating-priority first-one finder: returns the first set bit of elig,
// searching circularly upward starting at index start.
//   elig  : eligibility vector, one bit per queue
//   start : index searched first
//   found : at least one eligible queue exists
//   idx   : chosen queue (0 when nothing is found)
// -----------------------------------------------------------------------------
module qos_rr_pick
   import qos_pkg::*;
(
   input  logic [QUEUE_QUANTITY-1:0] elig,
   input  logic [W_QID-1:0]          start,
   output logic                      found,
   output logic [W_QID-1:0]          idx
);

   logic [W_QID-1:0] cand;

   // NOTE: every always_comb output gets a default before any branch, otherwise
   // a path that skips the assignment infers a latch.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = 0; k < QUEUE_QUANTITY; k++) begin
         cand = W_QID'((int'(start) + k) % QUEUE_QUANTITY);
         if (!found && elig[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/qos_scheduler.sv
// -----------------------------------------------------------------------------
// qos_scheduler
// Egress scheduler choosing which per-class FIFO is popped each cycle.
// Modes: round robin, weighted round robin (per-queue quota) and table-driven
// arbitration (entry list of queue/weight pairs scanned from a rotating pointer).
// A burst is granted in a one-cycle ARB state and served in SERVE; configuration
// is only sampled in ARB.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   enb                   : global enable; low freezes state and forces pop=0
//   seleccion_roundRobin  : arbitration mode
//   pesos                 : per-queue WRR weight, queue i at [6i+5:6i]
//   pesosArbitraje        : per-table-entry weight
//   selecciones           : per-table-entry queue index
//   bus                   : FIFO-side bundle (qos_scheduler_if.master)
//   stats_out             : per-queue saturating pop counters, 16 bits each
//                           (present only when QOS_SCHED_STATS_EN is defined)
// -----------------------------------------------------------------------------
module qos_scheduler
   import qos_pkg::*;
(
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enb,
   input  logic [W_MODE-1:0]                seleccion_roundRobin,
   input  logic [QUEUE_QUANTITY*W_WEIGHT-1:0] pesos,
   input  logic [TABLE_SIZE*W_WEIGHT-1:0]   pesosArbitraje,
   input  logic [TABLE_SIZE*W_QID-1:0]      selecciones,
   qos_scheduler_if.master                  bus
`ifdef QOS_SCHED_STATS_EN
   ,
   output logic [QUEUE_QUANTITY*16-1:0]     stats_out
`endif
);

   state_t              state_q, state_n;
   logic [W_QID-1:0]    last_q, last_n;
   logic [W_TP-1:0]     tp_q, tp_n;
   logic [W_WEIGHT-1:0] cnt_q, cnt_n;
   logic [W_QID-1:0]    gid_q, gid_n;

   logic [QUEUE_QUANTITY-1:0] pop_vec;
   logic [QUEUE_QUANTITY-1:0] wrr_elig, rr_elig;
   logic                      any_ready;
   logic [W_QID-1:0]          rr_start, rr_idx;
   logic                      rr_found;
   logic                      tbl_found;
   logic [W_QID-1:0]          tbl_q;
   logic [W_WEIGHT-1:0]       tbl_w;
   logic [W_TP-1:0]           tbl_next;

   assign any_ready = |(~bus.fifo_empty);
   assign rr_start  = (last_q == W_QID'(QUEUE_QUANTITY - 1)) ? '0 : last_q + 1'b1;

   // Weight-0 queues are invisible to WRR so they are never granted.
   always_comb begin
      wrr_elig = '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++)
         wrr_elig[i] = !bus.fifo_empty[i] && (pesos[i*W_WEIGHT +: W_WEIGHT] != '0);
   end

   assign rr_elig = (seleccion_roundRobin == MODE_WRR) ? wrr_elig : ~bus.fifo_empty;

   qos_rr_pick u_rr_pick (
      .elig  (rr_elig),
      .start (rr_start),
      .found (rr_found),
      .idx   (rr_idx)
   );

   // Table scan: first entry from tp whose queue has data and whose weight is
   // non-zero; the pointer then advances past the chosen entry.
   always_comb begin : table_scan
      int                  e;
      logic [W_QID-1:0]    q_e;
      logic [W_WEIGHT-1:0] w_e;
      tbl_found = 1'b0;
      tbl_q     = '0;
      tbl_w     = '0;
      tbl_next  = tp_q;
      e         = 0;
      q_e       = '0;
      w_e       = '0;
      for (int k = 0; k < TABLE_SIZE; k++) begin
         e   = (int'(tp_q) + k) % TABLE_SIZE;
         q_e = selecciones[e*W_QID +: W_QID];
         w_e = pesosArbitraje[e*W_WEIGHT +: W_WEIGHT];
         if (!tbl_found && !bus.fifo_empty[q_e] && (w_e != '0)) begin
            tbl_found = 1'b1;
            tbl_q     = q_e;
            tbl_w     = w_e;
            tbl_next  = (e == TABLE_SIZE - 1) ? '0 : W_TP'(e + 1);
         end
      end
   end

   always_comb begin : fsm_next
      state_n = state_q;
      last_n  = last_q;
      tp_n    = tp_q;
      cnt_n   = cnt_q;
      gid_n   = gid_q;
      pop_vec = '0;
      unique case (state_q)
         IDLE: begin
            if (any_ready) state_n = ARB;
         end
         ARB: begin
            state_n = IDLE;
            if (seleccion_roundRobin == MODE_TABLE) begin
               if (tbl_found) begin
                  state_n = SERVE;
                  gid_n   = tbl_q;
                  cnt_n   = tbl_w;
                  tp_n    = tbl_next;
               end
            end else if (rr_found) begin
               state_n = SERVE;
               gid_n   = rr_idx;
               cnt_n   = (seleccion_roundRobin == MODE_WRR) ?
                         pesos[int'(rr_idx)*W_WEIGHT +: W_WEIGHT] : W_WEIGHT'(1);
            end
         end
         SERVE: begin
            pop_vec[gid_q] = !bus.dest_full && !bus.fifo_empty[gid_q];
            if (pop_vec[gid_q]) cnt_n = cnt_q - 1'b1;
            // An emptied queue gives up its slot; leftover quota is dropped.
            if (bus.fifo_empty[gid_q] || (pop_vec[gid_q] && cnt_q == W_WEIGHT'(1))) begin
               last_n  = gid_q;
               state_n = any_ready ? ARB : IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         last_q  <= W_QID'(QUEUE_QUANTITY - 1);
         tp_q    <= '0;
         cnt_q   <= '0;
         gid_q   <= '0;
      end else if (enb) begin
         state_q <= state_n;
         last_q  <= last_n;
         tp_q    <= tp_n;
         cnt_q   <= cnt_n;
         gid_q   <= gid_n;
      end
   end

   assign bus.pop         = enb ? pop_vec : '0;
   assign bus.grant_id    = gid_q;
   assign bus.grant_valid = (state_q == SERVE);
   assign bus.busy        = (state_q != IDLE);

`ifdef QOS_SCHED_STATS_EN
   logic [15:0] stat_q [QUEUE_QUANTITY];

   // NOTE: this small counter array is reset explicitly because its contents are
   // architecturally visible; large data memories would normally be left unreset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < QUEUE_QUANTITY; i++) stat_q[i] <= '0;
      end else begin
         for (int i = 0; i < QUEUE_QUANTITY; i++)
            if (bus.pop[i] && stat_q[i] != 16'hFFFF) stat_q[i] <= stat_q[i] + 16'd1;
      end
   end

   always_comb begin
      stats_out = '0;
      for (int i = 0; i < QUEUE_QUANTITY; i++) stats_out[i*16 +: 16] = stat_q[i];
   end
`endif

endmodule

// File: tb/tb_qos_scheduler.sv
// -----------------------------------------------------------------------------
// tb_qos_scheduler
// Directed bench for qos_scheduler. The environment keeps a word count per FIFO
// and drives fifo_empty from it; pops are sampled on the falling edge and
// applied to the counts after the next rising edge.
// Optional QOS_SCHED_STATS_EN build connects stats_out.
// -----------------------------------------------------------------------------
module tb_qos_scheduler;
   import qos_pkg::*;

   logic        clk;
   logic        rst;
   logic        enb;
   logic [1:0]  mode;
   logic [23:0] pesos;
   logic [47:0] pesos_arb;
   logic [15:0] selecciones;
`ifdef QOS_SCHED_STATS_EN
   logic [63:0] stats_out;
`endif

   qos_scheduler_if bus ();

   qos_scheduler dut (
      .clk                  (clk),
      .rst                  (rst),
      .enb                  (enb),
      .seleccion_roundRobin (mode),
      .pesos                (pesos),
      .pesosArbitraje       (pesos_arb),
      .selecciones          (selecciones),
      .bus                  (bus)
`ifdef QOS_SCHED_STATS_EN
      ,
      .stats_out            (stats_out)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_err = 0;
   int n_onehot_bad = 0;
   int words [4];
   int seq [$];
   int exp_q [$];
   logic [3:0] pop_h [$];
   logic       gv_h  [$];
   logic [1:0] gid_h [$];
   int tq [8] = '{2, 0, 2, 1, 3, 0, 1, 3};
   int tw [8] = '{2, 1, 0, 1, 1, 0, 1, 2};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < 4; i++) bus.fifo_empty[i] = (words[i] == 0);
   endtask

   task automatic clear_logs();
      seq.delete();
      pop_h.delete();
      gv_h.delete();
      gid_h.delete();
   endtask

   // One clock cycle: sample outputs mid-cycle, then apply pops after the edge.
   task automatic cycle();
      logic [3:0] p;
      @(negedge clk);
      p = bus.pop;
      if (!$onehot0(p)) n_onehot_bad++;
      pop_h.push_back(p);
      gv_h.push_back(bus.grant_valid);
      gid_h.push_back(bus.grant_id);
      for (int i = 0; i < 4; i++)
         if (p[i]) begin
            seq.push_back(i);
            if (words[i] > 0) words[i]--;
         end
      @(posedge clk);
      #1;
      refresh();
   endtask

   task automatic check_seq(input string tag, input int exp[$]);
      check($sformatf("%s len", tag), seq.size(), exp.size());
      for (int i = 0; i < exp.size(); i++)
         check($sformatf("%s[%0d]", tag, i), (i < seq.size()) ? seq[i] : -1, exp[i]);
   endtask

   task automatic set_pesos(input int w0, input int w1, input int w2, input int w3);
      pesos = {6'(w3), 6'(w2), 6'(w1), 6'(w0)};
   endtask

   task automatic fill(input int n);
      for (int i = 0; i < 4; i++) words[i] = n;
      refresh();
   endtask

   // Leaves the bench at 1 time unit after a rising edge with reset released.
   task automatic apply_reset();
      rst = 1'b0;
      enb = 1'b0;
      bus.dest_full = 1'b0;
      fill(0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      enb = 1'b0;
      mode = 2'd0;
      pesos = '0;
      pesos_arb = '0;
      selecciones = '0;
      bus.dest_full = 1'b0;
      fill(0);
      #1 rst = 1'b0;
      #1;
      check("rst grant_valid", bus.grant_valid, 0);
      check("rst busy", bus.busy, 0);
      check("rst pop", bus.pop, 0);
      check("rst grant_id", bus.grant_id, 0);
      apply_reset();

      // ---- Test 1: plain RR, weights ignored, enb low keeps IDLE ----
      mode = 2'd0;
      set_pesos(0, 0, 0, 0);
      fill(100);
      clear_logs();
      repeat (2) cycle();
      check("t1 enb low busy", bus.busy, 0);
      check("t1 enb low pops", seq.size(), 0);
      enb = 1'b1;
      clear_logs();
      repeat (16) cycle();
      exp_q = '{0, 1, 2, 3, 0, 1, 2};
      check_seq("t1 rr", exp_q);
      check("t1 idle gv", gv_h[0], 0);
      check("t1 arb gv", gv_h[1], 0);
      check("t1 serve gv", gv_h[2], 1);
      check("t1 bubble pop", pop_h[3], 0);

      // ---- Test 2: WRR weights 3/1/0/2 ----
      apply_reset();
      mode = 2'd1;
      set_pesos(3, 1, 0, 2);
      fill(100);
      enb = 1'b1;
      clear_logs();
      repeat (16) cycle();
      exp_q = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1};
      check_seq("t2 wrr", exp_q);

      // ---- Test 3: table mode with zero-weight entries and pointer wrap ----
      apply_reset();
      mode = 2'd2;
      set_pesos(0, 0, 0, 0);
      for (int e = 0; e < 8; e++) begin
         selecciones[2*e +: 2] = 2'(tq[e]);
         pesos_arb[6*e +: 6]   = 6'(tw[e]);
      end
      fill(100);
      enb = 1'b1;
      clear_logs();
      repeat (20) cycle();
      exp_q = '{2, 2, 0, 1, 3, 1, 3, 3, 2, 2, 0};
      check_seq("t3 table", exp_q);

      // ---- Test 4: quota larger than queue occupancy ----
      apply_reset();
      mode = 2'd1;
      set_pesos(5, 1, 1, 1);
      fill(100);
      words[0] = 2;
      refresh();
      enb = 1'b1;
      clear_logs();
      repeat (9) cycle();
      exp_q = '{0, 0, 1, 2};
      check_seq("t4 drain", exp_q);
      check("t4 empty serve pop", pop_h[4], 0);
      check("t4 empty serve gv", gv_h[4], 1);
      check("t4 rearb gv", gv_h[5], 0);
      check("t4 next gid", gid_h[6], 1);

      // ---- Test 5: dest_full stall then enable low mid-burst ----
      apply_reset();
      mode = 2'd1;
      set_pesos(4, 1, 1, 1);
      fill(100);
      enb = 1'b1;
      clear_logs();
      for (int c = 0; c < 15; c++) begin
         bus.dest_full = (c >= 3 && c <= 6);
         enb = !(c >= 7 && c <= 9);
         cycle();
      end
      bus.dest_full = 1'b0;
      enb = 1'b1;
      for (int c = 3; c <= 9; c++) begin
         check($sformatf("t5 stall pop c%0d", c), pop_h[c], 0);
         check($sformatf("t5 stall gv c%0d", c), gv_h[c], 1);
         check($sformatf("t5 stall gid c%0d", c), gid_h[c], 0);
      end
      check("t5 resume pop", pop_h[10], 4'b0001);
      check("t5 last pop", pop_h[12], 4'b0001);
      check("t5 rearb gv", gv_h[13], 0);
      exp_q = '{0, 0, 0, 0, 1};
      check_seq("t5 burst", exp_q);

      // ---- Test 6: mode 3 behaves as RR; reset mid-SERVE ----
      apply_reset();
      mode = 2'd3;
      set_pesos(3, 0, 1, 1);
      fill(100);
      enb = 1'b1;
      clear_logs();
      repeat (4) cycle();
      #1;
      check("t6 pre pop", bus.pop, 4'b0010);
      check("t6 pre gid", bus.grant_id, 1);
      rst = 1'b0;
      #1;
      check("t6 rst pop", bus.pop, 0);
      check("t6 rst gv", bus.grant_valid, 0);
      check("t6 rst busy", bus.busy, 0);
      check("t6 rst gid", bus.grant_id, 0);
      @(posedge clk);
      #1 rst = 1'b1;
      clear_logs();
      repeat (3) cycle();
      check("t6 after arb gv", gv_h[1], 0);
      check("t6 first gid", gid_h[2], 0);
      check("t6 first pop", pop_h[2], 4'b0001);

      check("onehot pop", n_onehot_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
